hamming_tx: RTL and testbench
=============================

# hamming_tx

Hamming(7,4) encoder and bit-serial transmitter. Accepts a 4-bit nibble over a valid/ready handshake, computes the three parity bits, and shifts the 7-bit codeword out on a single line framed by a start bit and a stop bit. It is the sending end of the lab's Hamming link; the existing display-side decoder corrects any single-bit error in the received codeword.

## Interface
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit. Legal values are 1 and above.
- `clk` input, 1 bit: the single clock. All state changes on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `in_valid` input, 1 bit: `in_data` is valid.
- `in_ready` output, 1 bit: block can accept a nibble. High only in IDLE.
- `in_data` input, 4 bits: the nibble. `in_data[3]`=x0, `in_data[2]`=x1, `in_data[1]`=x2, `in_data[0]`=x3.
- `tx_serial` output, 1 bit: serial line. Idles high.
- `tx_busy` output, 1 bit: high from the cycle after accept until the frame ends.
- `codeword` output, 7 bits: registered copy of the codeword being sent, `{p0,p1,x0,p2,x1,x2,x3}`.
- `frame_done` output, 1 bit: one-cycle pulse when a frame completes.

## Operation
- Parity rules:
  - p0 = x0^x1^x3
  - p1 = x0^x2^x3
  - p2 = x1^x2^x3
- Codeword position 1 is `codeword[6]` (p0); position 7 is `codeword[0]` (x3).
- Accept occurs when `in_valid && in_ready`. On that edge:
  - the codeword is computed and latched into `codeword` and the shift register;
  - the FSM moves to START.
- `in_valid` outside IDLE is ignored. No input is buffered.
- FSM states:
  - IDLE: `tx_serial`=1, `in_ready`=1, `tx_busy`=0.
  - START: `tx_serial`=0 for `CLKS_PER_BIT` cycles.
  - DATA: sends 7 bits, `codeword[6]` first down to `codeword[0]`. Each bit is held `CLKS_PER_BIT` cycles. A 3-bit bit index runs 6 down to 0.
  - STOP: `tx_serial`=1 for `CLKS_PER_BIT` cycles, then returns to IDLE.
- Bit-time counter:
  - width is `$clog2(CLKS_PER_BIT)`, with a minimum of 1;
  - counts 0 to `CLKS_PER_BIT`-1 and advances the state or bit on its terminal count;
  - is cleared on each state entry.
- `frame_done` pulses high in the first IDLE cycle after STOP.
- `codeword` holds its value until the next accept.
- Reset asserted at any time, including mid-frame:
  - the FSM goes to IDLE immediately;
  - the frame is abandoned and not resumed.

## Timing
- Reset values:
  - `tx_serial`=1
  - `tx_busy`=0
  - `in_ready`=1
  - `codeword`=7'b0000000
  - `frame_done`=0
  - counters = 0
- Accept edge at cycle 0. From cycle 1:
  - `tx_serial` is low and `tx_busy` is high;
  - `in_ready` is low.
- Data bit k (k=0 is `codeword[6]`) occupies cycles 1+(k+1)·`CLKS_PER_BIT` through 1+(k+2)·`CLKS_PER_BIT`-1.
- STOP occupies cycles 1+8·`CLKS_PER_BIT` through 9·`CLKS_PER_BIT`.
- At cycle 9·`CLKS_PER_BIT`+1:
  - the FSM is in IDLE and `frame_done`=1;
  - `in_ready`=1 and `tx_busy`=0.
- A new accept may occur in that same cycle. The back-to-back frame period is 9·`CLKS_PER_BIT`+1 cycles.
- `tx_serial` is driven from a register, so the output is glitch-free.

## Configuration
- Macro: `HAMMING_TX_ERR_INJECT_EN`.
- When defined:
  - adds input `err_pos`, 3 bits;
  - at accept, if `err_pos` is 1–7, the bit at that codeword position (`codeword[7-err_pos]`) is inverted in both `codeword` and the transmitted frame;
  - `err_pos`=0 injects no error;
  - `err_pos` is sampled only on the accept edge.
- When undefined: the `err_pos` port does not exist, and the codeword is always the clean encoding.

## Test plan
- **Reset check.** Hold `rst_n`=0, then release. Required: `tx_serial`=1, `in_ready`=1, `tx_busy`=0, `codeword`=0.
- **Single frame.** `CLKS_PER_BIT`=4, `in_data`=4'b1011. Required:
  - `codeword`=7'b0110011;
  - serial sequence 0,0,1,1,0,0,1,1,1, each bit held 4 cycles;
  - `frame_done` pulses at cycle 37.
- **Encoding vectors.** Required codewords:
  - `in_data`=4'b0000 gives 7'b0000000;
  - `in_data`=4'b1111 gives 7'b1111111;
  - `in_data`=4'b1000 gives 7'b1110000.
- **Back-to-back and ignored input.** Hold `in_valid`=1 continuously with nibbles 4'b1011 then 4'b1000. Required:
  - the second accept occurs exactly when `frame_done`=1;
  - no nibble is lost or duplicated;
  - `in_data` changes while busy are ignored.
- **Reset mid-frame.** Assert `rst_n`=0 during DATA bit 3. Required:
  - `tx_serial`=1 and `tx_busy`=0 asynchronously;
  - the next frame after release starts cleanly.
- **Error injection** (macro defined). `in_data`=4'b1011, `err_pos`=3. Required:
  - `codeword`=7'b0100011;
  - fed to the decoder, the displayed value is corrected back to 4'b1011.

Source files
------------

// File: rtl/hamming_tx.sv
// Hamming(7,4) encoder and start/stop-framed bit-serial transmitter.
// Optional macro HAMMING_TX_ERR_INJECT_EN adds err_pos to invert one codeword position at accept.
module hamming_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
`ifdef HAMMING_TX_ERR_INJECT_EN
  input  logic [2:0] err_pos,
`endif
  output logic       tx_serial,
  output logic       tx_busy,
  output logic [6:0] codeword,
  output logic       frame_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t        r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [2:0]    r_bit_idx, w_bit_idx_next;
  logic [6:0]    r_shift, w_shift_next;
  logic [6:0]    r_codeword, w_codeword_next;
  logic          r_tx_serial, w_tx_serial_next;
  logic          r_frame_done, w_frame_done_next;

  logic          w_x0, w_x1, w_x2, w_x3;
  logic [6:0]    w_clean, w_err_mask, w_encoded;
  logic          w_accept, w_bit_end;

  assign w_x0 = in_data[3];
  assign w_x1 = in_data[2];
  assign w_x2 = in_data[1];
  assign w_x3 = in_data[0];

  // Layout {p0,p1,x0,p2,x1,x2,x3}: position 1 is bit 6, position 7 is bit 0.
  assign w_clean = {w_x0 ^ w_x1 ^ w_x3, w_x0 ^ w_x2 ^ w_x3, w_x0,
                    w_x1 ^ w_x2 ^ w_x3, w_x1, w_x2, w_x3};

`ifdef HAMMING_TX_ERR_INJECT_EN
  assign w_err_mask = (err_pos == 3'd0) ? 7'd0 : (7'b1 << (3'd7 - err_pos));
`else
  assign w_err_mask = 7'd0;
`endif

  assign w_encoded = w_clean ^ w_err_mask;
  assign w_accept  = in_valid && (r_state == S_IDLE);
  assign w_bit_end = (r_cnt == CNT_LAST);

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_bit_idx_next    = r_bit_idx;
    w_shift_next      = r_shift;
    w_codeword_next   = r_codeword;
    w_frame_done_next = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next    = S_START;
          w_cnt_next      = '0;
          w_shift_next    = w_encoded;
          w_codeword_next = w_encoded;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_next   = S_DATA;
          w_cnt_next     = '0;
          w_bit_idx_next = 3'd6;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_cnt_next = '0;
          if (r_bit_idx == 3'd0) begin
            w_state_next = S_STOP;
          end else begin
            w_bit_idx_next = r_bit_idx - 1'b1;
            w_shift_next   = {r_shift[5:0], 1'b0};
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_state_next      = S_IDLE;
          w_cnt_next        = '0;
          w_frame_done_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    // The line level is decided from the next state so the serial output can be a plain register.
    w_tx_serial_next = 1'b1;
    if (w_state_next == S_START) begin
      w_tx_serial_next = 1'b0;
    end else if (w_state_next == S_DATA) begin
      w_tx_serial_next = w_shift_next[6];
    end
  end

  // NOTE: non-blocking assignments in clocked logic, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_bit_idx    <= 3'd0;
      r_shift      <= 7'd0;
      r_codeword   <= 7'd0;
      r_tx_serial  <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_bit_idx    <= w_bit_idx_next;
      r_shift      <= w_shift_next;
      r_codeword   <= w_codeword_next;
      r_tx_serial  <= w_tx_serial_next;
      r_frame_done <= w_frame_done_next;
    end
  end

  assign in_ready   = (r_state == S_IDLE);
  assign tx_busy    = (r_state != S_IDLE);
  assign tx_serial  = r_tx_serial;
  assign codeword   = r_codeword;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_hamming_tx.sv
// Scoreboard bench for hamming_tx: stimulus queues expected codewords, a serial monitor
// deframes the line and compares against a position-based Hamming reference model.
module tb_hamming_tx;

  localparam int CPB    = 4;
  localparam int FRAME  = 9 * CPB + 1;
  localparam int BUDGET = 20 * CPB + 50;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       tx_serial;
  logic       tx_busy;
  logic [6:0] codeword;
  logic       frame_done;
`ifdef HAMMING_TX_ERR_INJECT_EN
  logic [2:0] err_pos;
  logic [2:0] ep_next;
`endif

  hamming_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
`ifdef HAMMING_TX_ERR_INJECT_EN
    .err_pos    (err_pos),
`endif
    .tx_serial  (tx_serial),
    .tx_busy    (tx_busy),
    .codeword   (codeword),
    .frame_done (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  logic [6:0] exp_q[$];
  int         acc_q[$];
  int         cyc        = 0;
  int         acc_cnt    = 0;
  int         last_acc   = 0;
  int         sent_cnt   = 0;
  int         done_cnt   = 0;
  int         stray_cnt  = 0;
  int         b2b_base   = 0;
  bit         b2b        = 1'b0;
  bit         mon_active = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: place data at positions 3,5,6,7; parity at 2^i covers every position with bit i set.
  function automatic logic [6:0] hamming_model(input logic [3:0] nib);
    bit         line[1:7];
    int         dpos[4] = '{3, 5, 6, 7};
    bit         par;
    logic [6:0] cw;
    for (int i = 0; i < 4; i++) line[dpos[i]] = nib[3-i];
    for (int p = 0; p < 3; p++) begin
      par = 1'b0;
      for (int pos = 1; pos <= 7; pos++)
        if (pos != (1 << p) && (pos & (1 << p)) != 0) par ^= line[pos];
      line[1 << p] = par;
    end
    for (int pos = 1; pos <= 7; pos++) cw[7-pos] = line[pos];
    return cw;
  endfunction

  function automatic logic [6:0] expected_for(input logic [3:0] nib);
    logic [6:0] cw;
    cw = hamming_model(nib);
`ifdef HAMMING_TX_ERR_INJECT_EN
    if (err_pos != 3'd0) cw[7-err_pos] = ~cw[7-err_pos];
`endif
    return cw;
  endfunction

`ifdef HAMMING_TX_ERR_INJECT_EN
  function automatic logic [3:0] decode_model(input logic [6:0] cw);
    bit line[1:7];
    int syn;
    syn = 0;
    for (int pos = 1; pos <= 7; pos++) begin
      line[pos] = cw[7-pos];
      if (line[pos]) syn ^= pos;
    end
    if (syn != 0) line[syn] = ~line[syn];
    return {line[3], line[5], line[6], line[7]};
  endfunction
`endif

  // Accept tracker: samples the handshake just before each rising edge.
  initial begin : acc_mon
    logic take, fd;
    forever begin
      @(negedge clk);
      #4;
      take = rst_n && in_valid && in_ready;
      fd   = frame_done;
      @(posedge clk);
      cyc++;
      if (take) begin
        if (b2b && acc_cnt > b2b_base) begin
          check("b2b_gap", cyc - last_acc, FRAME);
          check("b2b_on_frame_done", fd, 1);
        end
        acc_q.push_back(cyc);
        last_acc = cyc;
        acc_cnt++;
      end
    end
  end

  // Serial monitor: relative cycle 1 is the first cycle after the accept edge.
  initial begin : ser_mon
    int         rel, b, mon_acc, ser_err, ctl_err;
    logic       exp_bit;
    logic [6:0] mon_exp, rx;
    mon_acc = 0; ser_err = 0; ctl_err = 0; mon_exp = '0; rx = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_active = 1'b0;
        exp_q.delete();
        acc_q.delete();
      end else begin
        if (!mon_active) begin
          if (frame_done) stray_cnt++;
          if (!tx_serial) begin
            check("start_has_accept", (acc_q.size() > 0) && (exp_q.size() > 0), 1);
            if (acc_q.size() > 0 && exp_q.size() > 0) begin
              mon_active = 1'b1;
              mon_acc    = acc_q.pop_front();
              mon_exp    = exp_q.pop_front();
              ser_err    = 0;
              ctl_err    = 0;
              rx         = '0;
              check("start_latency", cyc - mon_acc + 1, 1);
            end
          end
        end
        if (mon_active) begin
          rel = cyc - mon_acc + 1;
          if (rel <= 9 * CPB) begin
            b = (rel - 1) / CPB;
            if (b == 0)      exp_bit = 1'b0;
            else if (b == 8) exp_bit = 1'b1;
            else             exp_bit = mon_exp[7-b];
            if (tx_serial !== exp_bit) ser_err++;
            if (tx_busy !== 1'b1 || in_ready !== 1'b0 || frame_done !== 1'b0 || codeword !== mon_exp)
              ctl_err++;
            if (b >= 1 && b <= 7 && (rel - 1) % CPB == CPB / 2) rx[7-b] = tx_serial;
          end else begin
            check("frame_bits", rx, mon_exp);
            check("serial_pattern_errs", ser_err, 0);
            check("ctrl_during_frame_errs", ctl_err, 0);
            check("frame_done_at_end", frame_done, 1);
            check("ready_at_end", in_ready, 1);
            check("busy_at_end", tx_busy, 0);
            check("codeword_held", codeword, mon_exp);
            done_cnt++;
            mon_active = 1'b0;
          end
        end
      end
    end
  end

  // Present a nibble and wait (bounded) for its accept edge; returns at the next falling edge.
  task automatic send_start(input logic [3:0] nib);
    int n, start_cnt;
    n = 0;
    start_cnt = acc_cnt;
    in_data  = nib;
    in_valid = 1'b1;
`ifdef HAMMING_TX_ERR_INJECT_EN
    err_pos = ep_next;
`endif
    exp_q.push_back(expected_for(nib));
    sent_cnt++;
    while (acc_cnt == start_cnt && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("accept_seen", acc_cnt - start_cnt, 1);
  endtask

  // Scramble inputs while busy; return on the falling edge where in_ready is back.
  task automatic send(input logic [3:0] nib, input bit hold);
    int n;
    send_start(nib);
    n = 0;
    while (!in_ready && n < BUDGET) begin
      in_data = 4'($urandom);
      if (!hold) in_valid = 1'($urandom);
`ifdef HAMMING_TX_ERR_INJECT_EN
      err_pos = 3'($urandom);
`endif
      @(negedge clk);
      n++;
    end
    if (!hold) in_valid = 1'b0;
    check("ready_after_frame", in_ready, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((mon_active || exp_q.size() != 0 || !in_ready) && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", mon_active || exp_q.size() != 0 || !in_ready, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    logic [3:0] vec_in [3] = '{4'b0000, 4'b1111, 4'b1000};
    logic [6:0] vec_cw [3] = '{7'b0000000, 7'b1111111, 7'b1110000};
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 4'd0;
`ifdef HAMMING_TX_ERR_INJECT_EN
    err_pos  = 3'd0;
    ep_next  = 3'd0;
`endif

    repeat (3) @(negedge clk);
    #1;
    check("rst_tx_serial", tx_serial, 1);
    check("rst_in_ready", in_ready, 1);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_codeword", codeword, 7'b0000000);
    check("rst_frame_done", frame_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_tx_serial", tx_serial, 1);

    // Single frame, 4'b1011.
    send(4'b1011, 1'b0);
    check("single_codeword", codeword, 7'b0110011);
    wait_idle();

    // Encoding vectors.
    for (int i = 0; i < 3; i++) begin
      send(vec_in[i], 1'b0);
      check("enc_vector", codeword, vec_cw[i]);
      wait_idle();
    end

    // Back-to-back with in_valid held and in_data churning while busy.
    b2b_base = acc_cnt;
    b2b      = 1'b1;
    send(4'b1011, 1'b1);
    send(4'b1000, 1'b1);
    in_valid = 1'b0;
    b2b      = 1'b0;
    check("b2b_last_codeword", codeword, 7'b1110000);
    wait_idle();

    // Reset during data bit 3 (relative cycles 1+4*CPB .. 5*CPB).
    send_start(4'b0110);
    in_valid = 1'b0;
    repeat (4 * CPB) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_tx_serial", tx_serial, 1);
    check("midrst_tx_busy", tx_busy, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_codeword", codeword, 7'b0000000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(4'b0101, 1'b0);
    check("after_rst_codeword", codeword, 7'b0100101);
    wait_idle();

`ifdef HAMMING_TX_ERR_INJECT_EN
    ep_next = 3'd3;
    send(4'b1011, 1'b0);
    check("inject_codeword", codeword, 7'b0100011);
    check("inject_decoded", decode_model(codeword), 4'b1011);
    ep_next = 3'd0;
    wait_idle();
`endif

    // Randomized traffic with idle gaps and spurious in_valid while busy.
    repeat (24) begin
`ifdef HAMMING_TX_ERR_INJECT_EN
      ep_next = 3'($urandom_range(0, 7));
`endif
      send(4'($urandom), 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle();

    check("stray_frame_done", stray_cnt, 0);
    check("accept_count", acc_cnt, sent_cnt);
    check("completed_frames", done_cnt, sent_cnt - 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
